alu_cmd_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the registered arithmetic unit and also collects its result. It accepts operand/function commands over a valid/ready handshake and buffers them in a small FIFO. It issues each command to the arithmetic unit as a single-cycle `arith_enable` pulse, captures the registered result, and returns it over a second valid/ready handshake. Divide-by-zero is trapped here and never issued.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_cmd_fifo.sv | 56 +++++
 rtl/alu_cmd_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: function codes and FSM states.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_DIV = 2'b11;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StIssue   = 2'b01,
    StCapture = 2'b10,
    StHold    = 2'b11
  } seq_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered count; full/empty derive from the count.
module alu_cmd_fifo #(
  parameter int unsigned Width = 34,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [Width-1:0]           wdata_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and count update; power-of-two depth makes pointer wrap implicit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time to the arithmetic unit, and
// returns each result over a valid/ready handshake. Divide-by-zero never issues.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned AluWidth  = 16,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [AluWidth-1:0] cmd_a_i,
  input  logic [AluWidth-1:0] cmd_b_i,
  input  logic [1:0]          cmd_fun_i,
  output logic [AluWidth-1:0] a_o,
  output logic [AluWidth-1:0] b_o,
  output logic [1:0]          alu_fun_o,
  output logic                arith_enable_o,
  input  logic [AluWidth-1:0] arith_out_i,
  input  logic                arith_flag_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [AluWidth-1:0] res_data_o,
  output logic                res_err_o,
  output logic                busy_o
);

  localparam int unsigned CmdW = 2 * AluWidth + 2;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  seq_state_e          state_q, state_d;
  logic [AluWidth-1:0] a_q, a_d, b_q, b_d, res_data_q, res_data_d;
  logic [1:0]          fun_q, fun_d;
  logic                res_err_q, res_err_d;

  logic [CmdW-1:0]     head;
  logic [AluWidth-1:0] head_a, head_b;
  logic [1:0]          head_fun;
  logic                fifo_full, fifo_empty, pop;
  logic [CntW-1:0]     fifo_count;

  // Command layout in the FIFO: {fun, a, b}.
  assign head_fun = head[CmdW-1 -: 2];
  assign head_a   = head[2*AluWidth-1 -: AluWidth];
  assign head_b   = head[AluWidth-1:0];

  alu_cmd_fifo #(
    .Width (CmdW),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cmd_valid_i && cmd_ready_o),
    .pop_i   (pop),
    .wdata_i ({cmd_fun_i, cmd_a_i, cmd_b_i}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign cmd_ready_o    = !fifo_full;
  assign a_o            = a_q;
  assign b_o            = b_q;
  assign alu_fun_o      = fun_q;
  assign res_data_o     = res_data_q;
  assign res_err_o      = res_err_q;
  assign arith_enable_o = (state_q == StIssue);
  assign res_valid_o    = (state_q == StHold);
  assign busy_o         = (state_q != StIdle) || (fifo_count != '0);

  // State and datapath registers; reset discards anything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      fun_q      <= ALU_ADD;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      fun_q      <= fun_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  // Next-state logic: pop, issue, capture, then hold until the consumer accepts.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    fun_d      = fun_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_fun == ALU_DIV && head_b == '0) begin
            // Trapped locally; operand registers keep the last issued command.
            res_data_d = '0;
            res_err_d  = 1'b1;
            state_d    = StHold;
          end else begin
            a_d     = head_a;
            b_d     = head_b;
            fun_d   = head_fun;
            state_d = StIssue;
          end
        end
      end
      StIssue: state_d = StCapture;
      StCapture: begin
        res_data_d = arith_out_i;
        res_err_d  = !arith_flag_i;
        state_d    = StHold;
      end
      StHold: begin
        if (res_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural arithmetic unit.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int unsigned W = 16;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0, cmd_ready;
  logic [W-1:0] cmd_a = '0, cmd_b = '0;
  logic [1:0]   cmd_fun = 2'b00;
  logic [W-1:0] a_o, b_o, arith_out, res_data;
  logic [1:0]   alu_fun;
  logic         arith_enable, arith_flag, res_valid, res_err, busy;
  logic         res_ready = 1'b1;
  logic         force_bad = 1'b0;

  int unsigned total = 0, passed = 0;
  int unsigned cyc = 0, acc_cyc = 0, en_cnt = 0, res_cnt = 0;

  typedef struct { logic [W-1:0] data; logic err; } res_t;
  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [1:0] fun; } iss_t;
  res_t exp_q[$];
  iss_t iss_q[$];

  alu_cmd_sequencer #(.AluWidth(W), .FifoDepth(D)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_a_i        (cmd_a),
    .cmd_b_i        (cmd_b),
    .cmd_fun_i      (cmd_fun),
    .a_o            (a_o),
    .b_o            (b_o),
    .alu_fun_o      (alu_fun),
    .arith_enable_o (arith_enable),
    .arith_out_i    (arith_out),
    .arith_flag_i   (arith_flag),
    .res_valid_o    (res_valid),
    .res_ready_i    (res_ready),
    .res_data_o     (res_data),
    .res_err_o      (res_err),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] f);
    logic [W-1:0] r;
    case (f)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_MUL: r = a * b;
      default: r = (b == '0) ? '0 : a / b;
    endcase
    return r;
  endfunction

  // Registered arithmetic unit: result and flag appear one edge after the enable.
  always @(posedge clk) begin
    if (rst) begin
      arith_out  <= '0;
      arith_flag <= 1'b0;
    end else begin
      arith_flag <= arith_enable && !force_bad;
      if (arith_enable) arith_out <= alu_model(a_o, b_o, alu_fun);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Compare process: every HOLD cycle and every issue pulse against the model queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid) begin
        check("res_has_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check("res_data", 32'(res_data), 32'(exp_q[0].data));
          check("res_err", 32'(res_err), 32'(exp_q[0].err));
          if (res_ready) begin
            void'(exp_q.pop_front());
            res_cnt++;
          end
        end
      end
      if (arith_enable) begin
        en_cnt++;
        check("issue_has_expected", 32'(iss_q.size() != 0), 32'd1);
        if (iss_q.size() != 0) begin
          check("issue_a", 32'(a_o), 32'(iss_q[0].a));
          check("issue_b", 32'(b_o), 32'(iss_q[0].b));
          check("issue_fun", 32'(alu_fun), 32'(iss_q[0].fun));
          void'(iss_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one command; returns #1 after the accepting edge.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] f);
    bit ok = 0;
    res_t r;
    iss_t s;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_fun = f;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    check("push_accepted", 32'(ok), 32'd1);
    if (f == ALU_DIV && b == '0) begin
      r.data = '0;
      r.err = 1'b1;
    end else begin
      r.data = alu_model(a, b, f);
      r.err = force_bad;
      s.a = a;
      s.b = b;
      s.fun = f;
      iss_q.push_back(s);
    end
    if (ok) exp_q.push_back(r);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [W-1:0] d, output logic e, output int unsigned lat);
    bit ok = 0;
    d = '0;
    e = 1'b0;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1;
        d = res_data;
        e = res_err;
        lat = cyc - acc_cyc;
        break;
      end
    end
    check("result_arrived", 32'(ok), 32'd1);
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, "_a"}, 32'(a_o), 32'd0);
    check({tag, "_b"}, 32'(b_o), 32'd0);
    check({tag, "_fun"}, 32'(alu_fun), 32'd0);
    check({tag, "_enable"}, 32'(arith_enable), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_data"}, 32'(res_data), 32'd0);
    check({tag, "_res_err"}, 32'(res_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] d;
    logic         e;
    int unsigned  lat, e0, r0;
    bit           ok;

    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check_zero_state("reset");
    step();

    // add 3+4: one issue pulse, 3-cycle latency
    e0 = en_cnt;
    push(16'h0003, 16'h0004, ALU_ADD);
    wait_result(d, e, lat);
    check("add_latency", lat, 32'd3);
    check("add_data", 32'(d), 32'h0007);
    check("add_err", 32'(e), 32'd0);
    step();
    step();
    check("add_one_pulse", en_cnt - e0, 32'd1);

    // sub wraps, mul keeps low bits; results in order
    push(16'h0000, 16'h0001, ALU_SUB);
    push(16'h0100, 16'h0100, ALU_MUL);
    wait_result(d, e, lat);
    check("sub_data", 32'(d), 32'h0000FFFF);
    step();
    wait_result(d, e, lat);
    check("mul_data", 32'(d), 32'h00000000);
    step();
    step();

    // divide by zero trapped without issue; operands untouched
    e0 = en_cnt;
    push(16'h0010, 16'h0000, ALU_DIV);
    wait_result(d, e, lat);
    check("div0_latency", lat, 32'd1);
    check("div0_data", 32'(d), 32'd0);
    check("div0_err", 32'(e), 32'd1);
    check("div0_a_kept", 32'(a_o), 32'h0100);
    check("div0_fun_kept", 32'(alu_fun), 32'(ALU_MUL));
    step();
    step();
    check("div0_no_pulse", en_cnt - e0, 32'd0);
    push(16'h0010, 16'h0003, ALU_DIV);
    wait_result(d, e, lat);
    check("div_data", 32'(d), 32'h0005);
    step();
    step();

    // backpressure: one in HOLD plus four queued fills the FIFO
    res_ready = 1'b0;
    r0 = res_cnt;
    for (int k = 0; k < 5; k++) push(16'(32'h20 + k), 16'h0001, ALU_ADD);
    repeat (3) step();
    @(negedge clk);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    step();
    res_ready = 1'b1;
    push(16'h0030, 16'h0002, ALU_MUL);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    check("drain_done", 32'(ok), 32'd1);
    check("drain_count", res_cnt - r0, 32'd6);
    step();

    // missing arith_flag reports an error but still completes
    force_bad = 1'b1;
    push(16'h0001, 16'h0001, ALU_ADD);
    wait_result(d, e, lat);
    check("noflag_err", 32'(e), 32'd1);
    check("noflag_data", 32'(d), 32'h0002);
    step();
    force_bad = 1'b0;
    step();
    push(16'h0005, 16'h0006, ALU_ADD);
    wait_result(d, e, lat);
    check("after_noflag_data", 32'(d), 32'h000B);
    check("after_noflag_err", 32'(e), 32'd0);
    step();
    step();

    // reset while the first of three commands is in CAPTURE
    e0 = en_cnt;
    push(16'h0001, 16'h0002, ALU_ADD);
    push(16'h0003, 16'h0004, ALU_SUB);
    push(16'h0005, 16'h0006, ALU_MUL);
    check("pre_reset_pulse", en_cnt - e0, 32'd1);
    rst = 1'b1;
    exp_q.delete();
    iss_q.delete();
    step();
    rst = 1'b0;
    e0 = en_cnt;
    @(negedge clk);
    check_zero_state("midreset");
    repeat (10) step();
    check("post_reset_no_pulse", en_cnt - e0, 32'd0);
    check("post_reset_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
